fir_output_requantizer: RTL and testbench

Receiving end of the FIR datapath's output stream: consumes the filter's full-precision `data_out`/`data_out_valid` accumulator stream, rounds and saturates it to Q1.15, and buffers the results in a small FIFO drained by a valid/ready consumer (DAC interface, capture RAM, or next DSP stage). The FIR output has no backpressure, so this block absorbs consumer stalls and reports loss explicitly rather than stalling the filter.

---
 rtl/fir_pkg.sv | 34 +++
 rtl/fir_rq_fifo.sv | 46 ++++
 rtl/fir_output_requantizer.sv | 90 +++++++++
 tb/tb_fir_output_requantizer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR-chain definitions: default widths, Q1.15 limits and the saturate helper
// used by the output requantizer and any other block that narrows to Q1.15.
package fir_pkg;

  localparam int ACC_WIDTH = 40;
  localparam int OUT_WIDTH = 16;
  localparam int SHIFT     = 15;

  localparam int Q15_MAX = 32767;
  localparam int Q15_MIN = -32768;

  typedef struct packed {
    logic        sat;
    logic [15:0] q;
  } rq_sample_t;

  // Clamp an already rounded-and-shifted value to Q1.15, flagging any clip.
  function automatic rq_sample_t q15_sat(input logic signed [63:0] s);
    localparam logic signed [63:0] HI = 64'(Q15_MAX);
    localparam logic signed [63:0] LO = 64'(Q15_MIN);
    rq_sample_t o;
    o.sat = 1'b0;
    o.q   = s[15:0];
    if (s > HI) begin
      o.sat = 1'b1;
      o.q   = 16'h7fff;
    end else if (s < LO) begin
      o.sat = 1'b1;
      o.q   = 16'h8000;
    end
    return o;
  endfunction

endpackage

// File: rtl/fir_rq_fifo.sv
// Synchronous FIFO for requantized samples; full-with-pop accepts the write,
// a write while full with no pop is reported on drop instead of stalling.
module fir_rq_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, empty, pop, wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  assign valid = !empty;
  assign data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fir_output_requantizer.sv
// Rounds/saturates the FIR accumulator stream to Q1.15 and buffers it for a valid/ready sink.
// Optional statistics counters are built only when FIR_RQ_STATS_EN is defined.
module fir_output_requantizer
  import fir_pkg::*;
#(
  parameter int ACC_WIDTH = fir_pkg::ACC_WIDTH,
  parameter int OUT_WIDTH = fir_pkg::OUT_WIDTH,
  parameter int SHIFT     = fir_pkg::SHIFT,
  parameter int DEPTH     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [ACC_WIDTH-1:0] data_in,
  input  logic                        data_in_valid,
  output logic        [OUT_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        sat_flag,
  output logic                        ovf,
  input  logic                        ovf_clr,
  output logic                 [15:0] sat_count,
  output logic                 [15:0] drop_count
);

  localparam int STAGES = 2;
  localparam logic signed [ACC_WIDTH:0] RND = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);

  logic [STAGES:1]             vld_pipe;
  logic signed [ACC_WIDTH:0]   r1;
  logic signed [ACC_WIDTH:0]   s1;
  rq_sample_t                  rq;
  logic [OUT_WIDTH-1:0]        q2;
  logic                        sat2;
  logic                        drop;

  // One guard bit keeps the rounding add from wrapping at the positive extreme.
  assign s1 = r1 >>> SHIFT;
  assign rq = q15_sat(64'(s1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      r1       <= '0;
      q2       <= '0;
      sat2     <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], data_in_valid};
      r1       <= {data_in[ACC_WIDTH-1], data_in} + RND;
      q2       <= rq.q;
      sat2     <= rq.sat;
    end
  end

  fir_rq_fifo #(
    .WIDTH (OUT_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_pipe[STAGES]),
    .push_data ({sat2, q2}),
    .ready     (out_ready),
    .data      ({sat_flag, out_data}),
    .valid     (out_valid),
    .drop      (drop)
  );

  // A drop in the same cycle as a clear must leave the loss visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

`ifdef FIR_RQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count  <= '0;
      drop_count <= '0;
    end else begin
      if (vld_pipe[STAGES] && sat2 && sat_count != 16'hffff) sat_count <= sat_count + 1'b1;
      if (drop && drop_count != 16'hffff) drop_count <= drop_count + 1'b1;
    end
  end
`else
  assign sat_count  = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_fir_output_requantizer.sv
// Scoreboard bench for fir_output_requantizer: stimulus queues expected samples,
// a negedge monitor pops and compares on every out_valid && out_ready.
module tb_fir_output_requantizer;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [39:0] data_in;
  logic               data_in_valid;
  logic [15:0]        out_data;
  logic               out_valid;
  logic               out_ready;
  logic               sat_flag;
  logic               ovf;
  logic               ovf_clr;
  logic [15:0]        sat_count;
  logic [15:0]        drop_count;

  int vectors = 0;
  int errors  = 0;
  logic [16:0] exp_q [$];

`ifdef FIR_RQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  fir_output_requantizer #(.ACC_WIDTH(40), .OUT_WIDTH(16), .SHIFT(15), .DEPTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .sat_flag      (sat_flag),
    .ovf           (ovf),
    .ovf_clr       (ovf_clr),
    .sat_count     (sat_count),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got %0h with nothing expected", {sat_flag, out_data});
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if ({sat_flag, out_data} !== e) begin
          errors++;
          $display("FAIL out_sample: got sat=%0b data=%0h expected sat=%0b data=%0h",
                   sat_flag, out_data, e[16], e[15:0]);
        end
      end
    end
  end

  // Called at posedge+1; drives one valid cycle and returns at the next posedge+1.
  task automatic send(input logic signed [39:0] v, input logic [15:0] e, input bit sat, input bit keep);
    data_in       = v;
    data_in_valid = 1'b1;
    if (keep) exp_q.push_back({sat, e});
    @(posedge clk); #1;
    data_in_valid = 1'b0;
  endtask

  // Sends one sample and checks it is absent in cycle 2 and present in cycle 3.
  task automatic latency_probe(input string name, input logic signed [39:0] v, input logic [15:0] e);
    send(v, e, 1'b0, 1'b1);
    @(posedge clk); @(negedge clk);
    check({name, "_c2_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    check({name, "_c3_valid"}, 32'(out_valid), 32'd1);
    check({name, "_c3_data"}, 32'(out_data), 32'(e));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()) | 32'(out_valid) << 31, 32'd0);
  endtask

  initial begin
    rst = 1'b1; data_in = '0; data_in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_sat_flag", 32'(sat_flag), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_sat_count", 32'(sat_count), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    latency_probe("impulse", 40'sd536870912, 16'd16384);
    check("impulse_sat_flag_idle", 32'(sat_flag), 32'd0);

    send(40'sd16384,  16'd1, 1'b0, 1'b1);
    send(-40'sd16384, 16'd0, 1'b0, 1'b1);
    send(40'sd16383,  16'd0, 1'b0, 1'b1);
    drain("rounding");

    send(40'sd1073741824,  16'h7fff, 1'b1, 1'b1);
    send(-40'sd2147483648, 16'h8000, 1'b1, 1'b1);
    drain("saturation");
    check("sat_count", 32'(sat_count), STATS ? 32'd2 : 32'd0);

    // Overflow: nine samples into an eight-deep FIFO with the sink stalled.
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) send(40'(i) << 15, 16'(i), 1'b0, i <= 8);
    repeat (4) @(posedge clk);
    #1;
    check("ovf_set", 32'(ovf), 32'd1);
    check("drop_count", 32'(drop_count), STATS ? 32'd1 : 32'd0);
    check("full_valid", 32'(out_valid), 32'd1);
    check("hold_data", 32'(out_data), 32'd1);
    @(posedge clk); #1;
    check("hold_data_stable", 32'(out_data), 32'd1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf), 32'd0);
    drain("overflow");

    // Full FIFO with a pop in the same cycle as the next write.
    out_ready = 1'b0;
    for (int i = 10; i <= 17; i++) send(40'(i) << 15, 16'(i), 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    send(40'sd18 << 15, 16'd18, 1'b0, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("fullpop_valid", 32'(out_valid), 32'd1);
    check("fullpop_ovf", 32'(ovf), 32'd0);
    check("fullpop_drop_count", 32'(drop_count), STATS ? 32'd1 : 32'd0);
    check("fullpop_head", 32'(out_data), 32'd11);
    drain("fullpop");

    // Reset with four samples buffered.
    out_ready = 1'b0;
    for (int i = 20; i <= 23; i++) send(40'(i) << 15, 16'(i), 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_sat_count", 32'(sat_count), 32'd0);
    check("midrst_drop_count", 32'(drop_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    latency_probe("post_rst", 40'sd3 << 15, 16'd3);
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
